// File: rtl/tapped_shift_line.sv
// rtl/tapped_shift_line.sv - Tapped delay line with equally spaced taps and fill tracking
// Valid flags are pure decodes of the registered fill count, so no extra state is needed for them.
module tapped_shift_line #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 64,
  parameter int NUM_TAPS   = 3,
  parameter int TAP_STRIDE = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             sr_in,
  output logic [NUM_TAPS*WIDTH-1:0]    tap_data,
  output logic [NUM_TAPS-1:0]          tap_valid,
  output logic [WIDTH-1:0]             sr_out,
  output logic                         sr_out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         full
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [CW-1:0]    fill_q;

  // rst and clear share one path; either discards any shift in the same cycle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      fill_q <= '0;
    end else if (shift) begin
      stage[0] <= sr_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      if (fill_q != DEPTH_C) fill_q <= fill_q + 1'b1;
    end
  end

  for (genvar k = 1; k <= NUM_TAPS; k++) begin : g_tap
    localparam logic [CW-1:0] THR = CW'(k * TAP_STRIDE);
    assign tap_data[k*WIDTH-1 -: WIDTH] = stage[k*TAP_STRIDE-1];
    assign tap_valid[k-1]               = (fill_q >= THR);
  end

  assign sr_out       = stage[DEPTH-1];
  assign full         = (fill_q == DEPTH_C);
  assign sr_out_valid = full;
  assign fill_count   = fill_q;

endmodule

// File: tb/tb_tapped_shift_line.sv
// tb/tb_tapped_shift_line.sv - Self-checking bench for tapped_shift_line, default and swept configs
module tb_tapped_shift_line;

  logic        clk;
  logic        rst;
  logic        shift;
  logic        clear;
  logic [7:0]  sr_in;
  logic [15:0] sr_in16;

  logic [23:0] tap_data0;
  logic [2:0]  tap_valid0;
  logic [7:0]  sr_out0;
  logic        sr_out_valid0;
  logic [6:0]  fill_count0;
  logic        full0;

  logic [31:0] tap_data1;
  logic [1:0]  tap_valid1;
  logic [15:0] sr_out1;
  logic        sr_out_valid1;
  logic [3:0]  fill_count1;
  logic        full1;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  // Word history, most recent first; the swept line sees the first 10 entries
  logic [15:0] hist[$];

  assign sr_in16 = {~sr_in, sr_in};

  tapped_shift_line dut0 (
    .clk(clk), .rst(rst), .shift(shift), .clear(clear), .sr_in(sr_in),
    .tap_data(tap_data0), .tap_valid(tap_valid0), .sr_out(sr_out0),
    .sr_out_valid(sr_out_valid0), .fill_count(fill_count0), .full(full0)
  );

  tapped_shift_line #(.WIDTH(16), .DEPTH(10), .NUM_TAPS(2), .TAP_STRIDE(4)) dut1 (
    .clk(clk), .rst(rst), .shift(shift), .clear(clear), .sr_in(sr_in16),
    .tap_data(tap_data1), .tap_valid(tap_valid1), .sr_out(sr_out1),
    .sr_out_valid(sr_out_valid1), .fill_count(fill_count1), .full(full1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_at(input int j, input int depth);
    int n;
    n = (hist.size() < depth) ? hist.size() : depth;
    return (j < n) ? hist[j] : 16'h0;
  endfunction

  always @(posedge clk) begin
    if (rst || clear) hist.delete();
    else if (shift) begin
      hist.push_front({~sr_in, sr_in});
      if (hist.size() > 64) void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [23:0] e_tap0;
      logic [2:0]  e_v0;
      logic [31:0] e_tap1;
      logic [1:0]  e_v1;
      int          f0, f1;
      f0 = hist.size();
      f1 = (f0 > 10) ? 10 : f0;
      for (int k = 0; k < 3; k++) begin
        e_tap0[k*8 +: 8] = word_at(16*(k+1)-1, 64) & 16'h00FF;
        e_v0[k]          = (f0 >= 16*(k+1));
      end
      for (int k = 0; k < 2; k++) begin
        e_tap1[k*16 +: 16] = word_at(4*(k+1)-1, 10);
        e_v1[k]            = (f1 >= 4*(k+1));
      end
      chk("d0_tap_data", 32'(tap_data0), 32'(e_tap0));
      chk("d0_tap_valid", 32'(tap_valid0), 32'(e_v0));
      chk("d0_sr_out", 32'(sr_out0), 32'(word_at(63, 64) & 16'h00FF));
      chk("d0_sr_out_valid", 32'(sr_out_valid0), 32'(f0 == 64));
      chk("d0_full", 32'(full0), 32'(f0 == 64));
      chk("d0_fill_count", 32'(fill_count0), 32'(f0));
      chk("d1_tap_data", tap_data1, e_tap1);
      chk("d1_tap_valid", 32'(tap_valid1), 32'(e_v1));
      chk("d1_sr_out", 32'(sr_out1), 32'(word_at(9, 10)));
      chk("d1_full", 32'(full1), 32'(f1 == 10));
      chk("d1_sr_out_valid", 32'(sr_out_valid1), 32'(f1 == 10));
      chk("d1_fill_count", 32'(fill_count1), 32'(f1));
    end
  end

  task automatic step(input logic r, input logic c, input logic s, input logic [7:0] d);
    rst = r; clear = c; shift = s; sr_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_fill0"}, 32'(fill_count0), 32'd0);
    chk({tag, "_tap0"}, 32'(tap_data0), 32'd0);
    chk({tag, "_tv0"}, 32'(tap_valid0), 32'd0);
    chk({tag, "_out0"}, 32'(sr_out0), 32'd0);
    chk({tag, "_full0"}, 32'(full0), 32'd0);
    chk({tag, "_fill1"}, 32'(fill_count1), 32'd0);
    chk({tag, "_out1"}, 32'(sr_out1), 32'd0);
  endtask

  task automatic fill_pins(input int edges);
    case (edges)
      4:  chk("pin_d1_tv4", 32'(tap_valid1), 32'b01);
      8:  chk("pin_d1_tv8", 32'(tap_valid1), 32'b11);
      10: begin
        chk("pin_d1_full", 32'(full1), 32'd1);
        chk("pin_d1_out", 32'(sr_out1), 32'hFE01);
      end
      12: chk("pin_d1_fill_sat", 32'(fill_count1), 32'd10);
      16: begin
        chk("pin_tap1_16", 32'(tap_data0[7:0]), 32'd1);
        chk("pin_tv_16", 32'(tap_valid0), 32'b001);
        chk("pin_tap23_16", 32'(tap_data0[23:8]), 32'd0);
        chk("pin_out_16", 32'(sr_out0), 32'd0);
      end
      32: chk("pin_tv_32", 32'(tap_valid0), 32'b011);
      48: chk("pin_tv_48", 32'(tap_valid0), 32'b111);
      64: begin
        chk("pin_out_64", 32'(sr_out0), 32'd1);
        chk("pin_full_64", 32'(full0), 32'd1);
        chk("pin_fill_64", 32'(fill_count0), 32'd64);
      end
      65: begin
        chk("pin_out_65", 32'(sr_out0), 32'd2);
        chk("pin_fill_65", 32'(fill_count0), 32'd64);
      end
      default: ;
    endcase
  endtask

  initial begin
    rst = 1; clear = 0; shift = 1; sr_in = 8'hFF;
    // Reset held with shift active
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 8'hFF);
      chk_en = 1;
      chk_empty("rst");
    end
    step(0, 0, 0, 8'h00);
    chk_empty("post_rst");

    // Continuous fill, words 1, 2, 3, ...
    for (int i = 1; i <= 65; i++) begin
      step(0, 0, 1, 8'(i));
      fill_pins(i);
    end

    // Gapped shifting from empty
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 1, (i % 2 == 1) ? 8'h5A : 8'hA5);
      if (i == 62) chk("gap_out_63", 32'(sr_out0), 32'd0);
      if (i == 63) begin
        chk("gap_out_64", 32'(sr_out0), 32'hA5);
        chk("gap_full_64", 32'(full0), 32'd1);
      end
      step(0, 0, 0, 8'hC3);
      if (i == 63) chk("gap_hold", 32'(sr_out0), 32'hA5);
    end

    // Clear mid-fill with a shift attempted on the same edge
    step(0, 1, 0, 8'h00);
    for (int i = 1; i <= 40; i++) step(0, 0, 1, 8'(i + 100));
    chk("pre_clear_fill", 32'(fill_count0), 32'd40);
    step(0, 1, 1, 8'h77);
    chk_empty("clear");
    for (int i = 1; i <= 65; i++) begin
      step(0, 0, 1, 8'(i));
      fill_pins(i);
    end

    // Reset pulse with the line full and shifting
    step(1, 0, 1, 8'h33);
    chk_empty("mid_rst");
    step(0, 0, 1, 8'h44);
    chk("mid_rst_fill1", 32'(fill_count0), 32'd1);

    // Randomised mix, checked by the model every cycle
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, 8'($urandom));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tapped_shift_line.md
# tapped_shift_line

Parametrised tapped delay line: a WIDTH-bit by DEPTH-stage shift register with NUM_TAPS equally spaced taps and a final output. Each tap and the output carry a valid flag that tracks how far the line has filled since reset or clear. This is the next generation of the fixed 8x64 three-tap shifter and adds a synchronous reset, a flush input and fill tracking. It feeds FIR/correlator datapaths and delay-matching paths that must not consume words before real data has reached them.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 64, number of stages (≥2)
- NUM_TAPS, 3, number of intermediate taps (≥1)
- TAP_STRIDE, 16, stage spacing between taps; NUM_TAPS*TAP_STRIDE < DEPTH is required, and other configurations are unsupported

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- shift  in  1  advance the line by one stage this cycle
- clear  in  1  synchronous flush of data and fill state
- sr_in  in  WIDTH  word loaded into stage 0 on shift
- tap_data  out  NUM_TAPS*WIDTH  tap k (k=1..NUM_TAPS) at bits [k*WIDTH-1:(k-1)*WIDTH]
- tap_valid  out  NUM_TAPS  bit k-1 set when tap k holds a shifted-in word
- sr_out  out  WIDTH  last stage
- sr_out_valid  out  1  last stage holds a shifted-in word
- fill_count  out  $clog2(DEPTH+1)  number of shifts since reset/clear, saturating at DEPTH
- full  out  1  fill_count == DEPTH

## Operation
- Storage: stage[0..DEPTH-1], each WIDTH bits.
- On shift: stage[0] <= sr_in; stage[i] <= stage[i-1] for i = 1..DEPTH-1. With shift=0 all stages hold.
- Tap k = stage[k*TAP_STRIDE-1]; sr_out = stage[DEPTH-1]. Defaults give taps at stages 15, 31, 47 and the output at stage 63.
- fill_count: increments by 1 on each shift while < DEPTH. Holds at DEPTH, with no wrap.
- tap_valid[k-1] = (fill_count ≥ k*TAP_STRIDE); sr_out_valid = full = (fill_count == DEPTH). These are all decoded from registered fill_count, with no extra state.
- Priority per edge: rst > clear > shift.
  - rst or clear: every stage <= 0, fill_count <= 0. Any shift/sr_in in that cycle is discarded.
- Data and valid flags only change on a shift, clear or rst edge.
- rst mid-fill or with the line full: returns to the empty state in one edge. The first shift after the edge on which rst deasserts behaves as the first word.

## Timing
- Reset values: all stages 0, tap_data 0, sr_out 0, tap_valid 0, sr_out_valid 0, fill_count 0, full 0.
- All outputs come directly from registers or from decode of registered fill_count, so there is no combinational path from any input to any output.
- Latency is counted in shift edges, not clock cycles. A word presented with shift on edge n:
  - appears on tap k after its (k*TAP_STRIDE)-th shift, counting edge n as the first;
  - appears on sr_out after DEPTH shifts.
- tap_valid[k-1] rises on the same edge the first word reaches tap k; sr_out_valid/full rises on the same edge the first word reaches sr_out.
- Idle cycles (shift=0) stretch latency by one cycle each and change no state.
- Throughput: one word per cycle with shift held high.

## Test plan
- Reset: drive sr_in=8'hFF, shift=1, rst=1 for 3 cycles. All outputs must be 0, and fill_count=0 at each edge and after rst deasserts.
- Fill/latency (defaults): shift=1 continuously, sr_in = 1,2,3,... (first word 1).
  - After 16 edges: tap 1 = 1 and tap_valid = 3'b001, with tap 2, tap 3 and sr_out all 0.
  - After 32 edges: tap_valid = 3'b011. After 48 edges: tap_valid = 3'b111.
  - After 64 edges: sr_out = 1, full = 1, fill_count = 64.
  - After 65 edges: sr_out = 2 and fill_count stays at 64.
- Gapped shift: alternate shift 1/0 with words A5, 5A, ...
  - Word A5 must reach sr_out exactly after its 64th shift (127 clock edges).
  - Outputs must be stable on every shift=0 cycle.
- Clear: fill to fill_count = 40, then assert clear with shift=1 and sr_in=8'h77.
  - Next edge: all stages 0, fill_count 0, tap_valid 0.
  - Word 77 must not appear anywhere.
  - Refill must then behave as in the fill/latency scenario.
- Reset mid-operation: with the line full and shifting, pulse rst for one cycle. The empty state must appear on that edge; continued shifting must restart fill_count from 1.
- Parameter sweep: WIDTH=16, DEPTH=10, NUM_TAPS=2, TAP_STRIDE=4.
  - Taps at stages 3 and 7; tap_valid bits rise at 4 and 8 shifts; full at 10.
  - fill_count is 4 bits wide and saturates at 10.
